apu_access_arbiter: RTL
=======================

Name: apu_access_arbiter

Overview:
Two-port arbiter that shares the single APU register interface between requester 0 (CPU bus bridge) and requester 1 (audio DMA engine). It accepts one transaction at a time with a valid/ready handshake and issues it to the APU as a single-cycle read or write strobe. It returns the registered read data and error to the owning requester. It sits between the SoC interconnect and the apu instance. The APU's address decode and address-range errors are passed through unchanged.

Parameters:
ADDR_WIDTH, 12, APU register address width.
STARVE_LIMIT, 4, consecutive losses by requester 1 before forced promotion; used only with APU_ARB_FIXED_PRIO_EN.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous active-low reset
reqN_valid_i  in  1  requester N (N=0,1) transaction request
reqN_write_i  in  1  1=write, 0=read
reqN_address_i  in  ADDR_WIDTH  register address
reqN_data_i  in  32  write data
reqN_strobe_i  in  4  write byte strobes
reqN_ready_o  out  1  request accepted this cycle
reqN_resp_valid_o  out  1  one-cycle response pulse
reqN_resp_data_o  out  32  read data, 0 for writes
reqN_resp_error_o  out  1  APU read/write error
apu_write_o  out  1  APU write strobe
apu_write_address_o  out  ADDR_WIDTH  APU write address
apu_write_data_o  out  32  APU write data
apu_write_strobe_o  out  4  APU byte strobes
apu_write_error_i  in  1  APU write error, same cycle as strobe
apu_read_o  out  1  APU read strobe
apu_read_address_o  out  ADDR_WIDTH  APU read address
apu_read_data_i  in  32  APU read data, same cycle as strobe
apu_read_error_i  in  1  APU read error, same cycle as strobe

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - FSM goes to IDLE; all outputs, latched fields and response registers are 0.
  - last_grant=1, so requester 0 wins the first tie; starve counter=0.
  - An in-flight transaction is dropped and no response is issued.
- FSM states: IDLE -> ISSUE -> RESPOND -> IDLE. Fixed 3-cycle occupancy per transaction.
- IDLE:
  - Winner is chosen combinationally from the valids.
  - Only one valid: that requester wins.
  - Both valid: round-robin; the requester not equal to last_grant wins.
  - reqN_ready_o = (state==IDLE) & valid & winner==N. At most one ready is high.
  - On valid&ready: latch write, address, data, strobe and owner; update last_grant=owner; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - Drive exactly one of apu_write_o / apu_read_o high for one cycle, with the latched address, data and strobe.
  - Unused APU address/data outputs are 0.
  - Capture apu_read_data_i (reads only; 0 for writes) and the matching error input at the end of this cycle. Go to RESPOND.
- RESPOND:
  - reqOwner_resp_valid_o=1 for one cycle with the captured data and error.
  - Non-owner response outputs stay 0. Go to IDLE.
- Latency: accept at cycle T, APU strobe at T+1, response at T+2. New acceptance is possible at T+3.
- Requesters may drop valid before acceptance; no transaction is recorded. Fields need only be valid in the accept cycle.
- Response data/error outputs hold their value only during resp_valid; they return to 0 otherwise.
- Back-to-back: a requester with valid held high continuously alternates with the other under contention. It gets every slot if alone.

Optional Feature:
APU_ARB_FIXED_PRIO_EN:
- Defined:
  - Requester 0 wins all ties.
  - A 3-bit-minimum starve counter increments each time requester 1 is valid in IDLE but loses. It clears when requester 1 is granted.
  - When counter==STARVE_LIMIT, requester 1 wins the next tie; the counter then clears.
- Undefined: pure round-robin as above; counter logic absent.

Test Plan:
- Single write: req0 write addr 0x800, data 0xDEADBEEF, strobe 0xF -> ready0 at T, apu_write_o=1 with those fields at T+1, resp_valid0=1 with data 0 and error 0 at T+2.
- Single read: req1 read addr 0x004, APU returns 0x12345678 with error 0 -> resp_valid1 at T+2, resp_data1=0x12345678; resp_valid0 stays 0.
- Contention (round-robin build): both valid continuously from reset -> grants in order 0,1,0,1 at cycles 0,3,6,9. APU strobes never overlap.
- Error pass-through: req0 read addr 0xFFF with apu_read_error_i=1 -> resp_error0=1, resp_data0=0x12345678 passed through as driven by the APU.
- Reset mid-operation: assert rst_n_i=0 during ISSUE -> next cycle all outputs 0, no resp_valid; after release, req0 wins the first tie.
- Starvation (APU_ARB_FIXED_PRIO_EN, STARVE_LIMIT=4): both valid continuously -> grants 0,0,0,0,1,0,0,0,0,1.

Source files
------------

// File: rtl/apu_access_arbiter.sv
// apu_access_arbiter: shares the single APU register interface between the
// CPU bus bridge (requester 0) and the audio DMA engine (requester 1).
// One transaction at a time: accept in IDLE, strobe the APU in ISSUE,
// return the captured read data / error in RESPOND.
//
// Build option: define APU_ARB_FIXED_PRIO_EN to give requester 0 priority on
// ties, with a starvation counter that promotes requester 1 after
// STARVE_LIMIT consecutive losses. When it is undefined, ties are resolved
// round-robin.
module apu_access_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,

  input  logic                  req0_valid_i,
  input  logic                  req0_write_i,
  input  logic [ADDR_WIDTH-1:0] req0_address_i,
  input  logic [31:0]           req0_data_i,
  input  logic [3:0]            req0_strobe_i,
  output logic                  req0_ready_o,
  output logic                  req0_resp_valid_o,
  output logic [31:0]           req0_resp_data_o,
  output logic                  req0_resp_error_o,

  input  logic                  req1_valid_i,
  input  logic                  req1_write_i,
  input  logic [ADDR_WIDTH-1:0] req1_address_i,
  input  logic [31:0]           req1_data_i,
  input  logic [3:0]            req1_strobe_i,
  output logic                  req1_ready_o,
  output logic                  req1_resp_valid_o,
  output logic [31:0]           req1_resp_data_o,
  output logic                  req1_resp_error_o,

  output logic                  apu_write_o,
  output logic [ADDR_WIDTH-1:0] apu_write_address_o,
  output logic [31:0]           apu_write_data_o,
  output logic [3:0]            apu_write_strobe_o,
  input  logic                  apu_write_error_i,
  output logic                  apu_read_o,
  output logic [ADDR_WIDTH-1:0] apu_read_address_o,
  input  logic [31:0]           apu_read_data_i,
  input  logic                  apu_read_error_i
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;

  // APU-facing registers double as the latched transaction fields: they are
  // loaded on acceptance and cleared once the ISSUE cycle is over, so the
  // unused side of the APU interface is always 0.
  logic                  apu_write_q, apu_write_d;
  logic [ADDR_WIDTH-1:0] apu_waddr_q, apu_waddr_d;
  logic [31:0]           apu_wdata_q, apu_wdata_d;
  logic [3:0]            apu_wstrb_q, apu_wstrb_d;
  logic                  apu_read_q, apu_read_d;
  logic [ADDR_WIDTH-1:0] apu_raddr_q, apu_raddr_d;

  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  resp_error_q, resp_error_d;

  logic                  in_idle;
  logic                  tie;
  logic                  win1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_data;
  logic [3:0]            sel_strb;

`ifdef APU_ARB_FIXED_PRIO_EN
  // Wide enough to hold STARVE_LIMIT, never narrower than 3 bits.
  localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  starve_full;

  assign starve_full = (starve_q == STARVE_MAX);
`else
  // Requester that was granted most recently; the other one wins a tie.
  logic                  last_grant_q, last_grant_d;

  // The starvation limit only matters for the fixed-priority build.
  logic                  unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // Winner selection and request mux; ready is only offered in IDLE and
  // never while reset is being applied.
  always_comb begin
    in_idle = (state_q == ST_IDLE) && rst_n_i;
    tie     = req0_valid_i && req1_valid_i;
`ifdef APU_ARB_FIXED_PRIO_EN
    win1    = tie ? starve_full : req1_valid_i;
`else
    win1    = tie ? !last_grant_q : req1_valid_i;
`endif
    gnt0    = in_idle && req0_valid_i && !win1;
    gnt1    = in_idle && req1_valid_i && win1;

    sel_write = win1 ? req1_write_i   : req0_write_i;
    sel_addr  = win1 ? req1_address_i : req0_address_i;
    sel_data  = win1 ? req1_data_i    : req0_data_i;
    sel_strb  = win1 ? req1_strobe_i  : req0_strobe_i;
  end

  // Next-state logic for the IDLE -> ISSUE -> RESPOND sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    apu_write_d  = 1'b0;
    apu_waddr_d  = '0;
    apu_wdata_d  = 32'd0;
    apu_wstrb_d  = 4'd0;
    apu_read_d   = 1'b0;
    apu_raddr_d  = '0;
    resp_valid_d = 1'b0;
    resp_data_d  = 32'd0;
    resp_error_d = 1'b0;
`ifdef APU_ARB_FIXED_PRIO_EN
    starve_d     = starve_q;
`else
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          state_d     = ST_ISSUE;
          owner_d     = gnt1;
          apu_write_d = sel_write;
          apu_read_d  = !sel_write;
          if (sel_write) begin
            apu_waddr_d = sel_addr;
            apu_wdata_d = sel_data;
            apu_wstrb_d = sel_strb;
          end else begin
            apu_raddr_d = sel_addr;
          end
`ifdef APU_ARB_FIXED_PRIO_EN
          // Requester 1 only loses while valid when requester 0 takes a tie.
          if (gnt1) begin
            starve_d = '0;
          end else if (req1_valid_i) begin
            starve_d = starve_q + 1'b1;
          end
`else
          last_grant_d = gnt1;
`endif
        end
      end

      ST_ISSUE: begin
        // The APU answers in the same cycle as the strobe.
        state_d      = ST_RESPOND;
        resp_valid_d = 1'b1;
        resp_data_d  = apu_read_q ? apu_read_data_i : 32'd0;
        resp_error_d = apu_read_q ? apu_read_error_i : apu_write_error_i;
      end

      ST_RESPOND: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state register for FSM, latched fields and response; a reset
  // drops any in-flight transaction without a response.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      apu_write_q  <= 1'b0;
      apu_waddr_q  <= '0;
      apu_wdata_q  <= 32'd0;
      apu_wstrb_q  <= 4'd0;
      apu_read_q   <= 1'b0;
      apu_raddr_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_error_q <= 1'b0;
`ifdef APU_ARB_FIXED_PRIO_EN
      starve_q     <= '0;
`else
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      apu_write_q  <= apu_write_d;
      apu_waddr_q  <= apu_waddr_d;
      apu_wdata_q  <= apu_wdata_d;
      apu_wstrb_q  <= apu_wstrb_d;
      apu_read_q   <= apu_read_d;
      apu_raddr_q  <= apu_raddr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
`ifdef APU_ARB_FIXED_PRIO_EN
      starve_q     <= starve_d;
`else
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign req0_ready_o        = gnt0;
  assign req1_ready_o        = gnt1;

  assign apu_write_o         = apu_write_q;
  assign apu_write_address_o = apu_waddr_q;
  assign apu_write_data_o    = apu_wdata_q;
  assign apu_write_strobe_o  = apu_wstrb_q;
  assign apu_read_o          = apu_read_q;
  assign apu_read_address_o  = apu_raddr_q;

  // Route the single response register to the owner; the other port sees 0.
  assign req0_resp_valid_o   = resp_valid_q && !owner_q;
  assign req0_resp_data_o    = (resp_valid_q && !owner_q) ? resp_data_q : 32'd0;
  assign req0_resp_error_o   = resp_valid_q && !owner_q && resp_error_q;
  assign req1_resp_valid_o   = resp_valid_q && owner_q;
  assign req1_resp_data_o    = (resp_valid_q && owner_q) ? resp_data_q : 32'd0;
  assign req1_resp_error_o   = resp_valid_q && owner_q && resp_error_q;

endmodule
